// File: rtl/magnitude_power_estimator.sv
// rtl/magnitude_power_estimator.sv - windowed mean-magnitude slicer reference and mapper power estimator
// Optional feature macro: MAG_EST_DC_OFFSET_EN (adds per-channel dc_offset output)
module magnitude_power_estimator #(
    parameter int          DATA_WIDTH = 18,
    parameter int          NUM_CH     = 1,
    parameter int          LOG2_N     = 20,
    parameter logic [3:0]  P_AVE_MULT = 4'd5
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              sym_clk_ena,
    input  logic                              restart,
    input  logic [NUM_CH*DATA_WIDTH-1:0]      decision_variable,
    output logic signed [DATA_WIDTH-1:0]      reference_level,
    output logic signed [2*DATA_WIDTH+3:0]    mapper_out_power,
    output logic                              est_valid,
`ifdef MAG_EST_DC_OFFSET_EN
    output logic [NUM_CH*DATA_WIDTH-1:0]      dc_offset,
`endif
    output logic [7:0]                        window_count
);

    localparam int MAG_W = DATA_WIDTH - 1;
    localparam int ACC_W = MAG_W + LOG2_N + NUM_CH - 1;
    localparam int SQ_W  = 2 * DATA_WIDTH;
    localparam int PWR_W = 2 * DATA_WIDTH + 4;

    localparam logic [MAG_W-1:0]  MAG_ONE = MAG_W'(1);
    localparam logic [LOG2_N-1:0] CNT_ONE = LOG2_N'(1);

    logic [NUM_CH*MAG_W-1:0] mags_flat;
    logic [ACC_W-1:0]        mag_sum;
    logic [ACC_W-1:0]        acc_next;
    logic                    last_sym;
    logic                    take_sample;
    logic                    terminal;

    logic [ACC_W-1:0]             acc_q,   acc_d;
    logic [LOG2_N-1:0]            cnt_q,   cnt_d;
    logic signed [DATA_WIDTH-1:0] ref_q,   ref_d;
    logic                         pend_q,  pend_d;
    logic signed [PWR_W-1:0]      pwr_q,   pwr_d;
    logic                         valid_q, valid_d;
    logic [7:0]                   wcnt_q,  wcnt_d;

    logic signed [SQ_W-1:0]  ref_sx;
    logic signed [SQ_W-1:0]  ref_sq;
    logic signed [PWR_W-1:0] sq_sx;
    logic signed [PWR_W-1:0] k_sx;
    logic signed [PWR_W-1:0] pwr_full;

    // Per-channel magnitude; the most negative code saturates to the largest positive magnitude
    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_mag
        logic [DATA_WIDTH-1:0] x;
        logic [MAG_W-1:0]      mag;
        assign x = decision_variable[ch*DATA_WIDTH +: DATA_WIDTH];

        // Two's complement absolute value with saturation of the minimum code
        always_comb begin
            if (!x[DATA_WIDTH-1]) begin
                mag = x[MAG_W-1:0];
            end else if (x[MAG_W-1:0] == '0) begin
                mag = '1;
            end else begin
                mag = ~x[MAG_W-1:0] + MAG_ONE;
            end
        end

        assign mags_flat[ch*MAG_W +: MAG_W] = mag;
    end

    // Sum of all channel magnitudes for the current symbol
    always_comb begin
        mag_sum = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            mag_sum = mag_sum + ACC_W'(mags_flat[ch*MAG_W +: MAG_W]);
        end
    end

    assign acc_next    = acc_q + mag_sum;
    assign last_sym    = &cnt_q;
    assign take_sample = sym_clk_ena && !restart;
    assign terminal    = take_sample && last_sym;

    // Power = P_AVE_MULT * reference_level^2, full precision (2s34 * 2s2 -> 4s36)
    assign ref_sx   = {{DATA_WIDTH{ref_q[DATA_WIDTH-1]}}, ref_q};
    assign ref_sq   = ref_sx * ref_sx;
    assign sq_sx    = {{4{ref_sq[SQ_W-1]}}, ref_sq};
    assign k_sx     = {{SQ_W{P_AVE_MULT[3]}}, P_AVE_MULT};
    assign pwr_full = sq_sx * k_sx;

    // Next-state: window accumulation, terminal capture, and the one-cycle-later power stage
    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ref_d   = ref_q;
        pend_d  = 1'b0;
        pwr_d   = pwr_q;
        valid_d = 1'b0;
        wcnt_d  = wcnt_q;

        // The pending power update is independent of restart
        if (pend_q) begin
            pwr_d   = pwr_full;
            valid_d = 1'b1;
            wcnt_d  = wcnt_q + 8'd1;
        end

        if (restart) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (sym_clk_ena) begin
            if (last_sym) begin
                acc_d  = '0;
                cnt_d  = '0;
                // Top MAG_W bits of the window sum are the mean magnitude
                ref_d  = {1'b0, acc_next[ACC_W-1 -: MAG_W]};
                pend_d = 1'b1;
            end else begin
                acc_d = acc_next;
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            ref_q   <= '0;
            pend_q  <= 1'b0;
            pwr_q   <= '0;
            valid_q <= 1'b0;
            wcnt_q  <= '0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ref_q   <= ref_d;
            pend_q  <= pend_d;
            pwr_q   <= pwr_d;
            valid_q <= valid_d;
            wcnt_q  <= wcnt_d;
        end
    end

`ifdef MAG_EST_DC_OFFSET_EN
    localparam int DC_W = DATA_WIDTH + LOG2_N;

    logic [NUM_CH-1:0][DC_W-1:0]       dc_acc_q, dc_acc_d;
    logic [NUM_CH-1:0][DATA_WIDTH-1:0] dc_q,     dc_d;

    // Per-channel signed sum of raw samples; mean taken by arithmetic shift at the terminal sample
    always_comb begin
        dc_acc_d = dc_acc_q;
        dc_d     = dc_q;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            logic [DC_W-1:0] dc_next;
            dc_next = dc_acc_q[ch]
                    + DC_W'($signed(decision_variable[ch*DATA_WIDTH +: DATA_WIDTH]));
            if (restart) begin
                dc_acc_d[ch] = '0;
            end else if (sym_clk_ena) begin
                if (last_sym) begin
                    dc_acc_d[ch] = '0;
                    dc_d[ch]     = dc_next[DC_W-1 -: DATA_WIDTH];
                end else begin
                    dc_acc_d[ch] = dc_next;
                end
            end
        end
    end

    // DC offset registers share the main reset
    always_ff @(posedge clk) begin
        if (reset) begin
            dc_acc_q <= '0;
            dc_q     <= '0;
        end else begin
            dc_acc_q <= dc_acc_d;
            dc_q     <= dc_d;
        end
    end

    assign dc_offset = dc_q;
`endif

    assign reference_level  = ref_q;
    assign mapper_out_power = pwr_q;
    assign est_valid        = valid_q;
    assign window_count     = wcnt_q;

endmodule

// File: tb/tb_magnitude_power_estimator.sv
// tb/tb_magnitude_power_estimator.sv - scoreboard bench for magnitude_power_estimator (NUM_CH=1 and NUM_CH=2, LOG2_N=2)
module tb_magnitude_power_estimator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, restart, sym1, sym2;
    logic [17:0] dv1;
    logic [35:0] dv2;

    logic signed [17:0] ref1, ref2;
    logic signed [39:0] pwr1, pwr2;
    logic               v1, v2;
    logic [7:0]         wc1, wc2;
`ifdef MAG_EST_DC_OFFSET_EN
    logic [17:0] dc1;
    logic [35:0] dc2;
`endif

    typedef struct {
        logic signed [17:0] ref_l;
        logic signed [39:0] pwr;
        logic [7:0]         wc;
        logic [35:0]        dc;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    exp_t e1, e2;
    int   n_tests = 0;
    int   n_fail  = 0;

    magnitude_power_estimator #(.DATA_WIDTH(18), .NUM_CH(1), .LOG2_N(2), .P_AVE_MULT(4'd5)) u_dut1 (
        .clk               (clk),
        .reset             (reset),
        .sym_clk_ena       (sym1),
        .restart           (restart),
        .decision_variable (dv1),
        .reference_level   (ref1),
        .mapper_out_power  (pwr1),
        .est_valid         (v1),
`ifdef MAG_EST_DC_OFFSET_EN
        .dc_offset         (dc1),
`endif
        .window_count      (wc1)
    );

    magnitude_power_estimator #(.DATA_WIDTH(18), .NUM_CH(2), .LOG2_N(2), .P_AVE_MULT(4'd5)) u_dut2 (
        .clk               (clk),
        .reset             (reset),
        .sym_clk_ena       (sym2),
        .restart           (restart),
        .decision_variable (dv2),
        .reference_level   (ref2),
        .mapper_out_power  (pwr2),
        .est_valid         (v2),
`ifdef MAG_EST_DC_OFFSET_EN
        .dc_offset         (dc2),
`endif
        .window_count      (wc2)
    );

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send1(input logic [17:0] v, input int gap);
        sym1 = 1'b1;
        dv1  = v;
        @(posedge clk);
        #1;
        sym1 = 1'b0;
        idle(gap);
    endtask

    task automatic send2(input logic [35:0] v);
        sym2 = 1'b1;
        dv2  = v;
        @(posedge clk);
        #1;
        sym2 = 1'b0;
    endtask

    task automatic win1(input logic [17:0] v);
        for (int i = 0; i < 4; i++) send1(v, 0);
    endtask

    task automatic push1(input logic signed [17:0] r, input logic signed [39:0] p,
                         input logic [7:0] w, input logic [35:0] d);
        exp_t e;
        e.ref_l = r; e.pwr = p; e.wc = w; e.dc = d;
        q1.push_back(e);
    endtask

    task automatic push2(input logic signed [17:0] r, input logic signed [39:0] p,
                         input logic [7:0] w, input logic [35:0] d);
        exp_t e;
        e.ref_l = r; e.pwr = p; e.wc = w; e.dc = d;
        q2.push_back(e);
    endtask

    // Monitor: pops the scoreboard whenever a DUT presents est_valid
    initial begin
        forever begin
            @(negedge clk);
            if (v1) begin
                if (q1.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_valid_dut1: est_valid=1, expected 0 (wc=%0d)", wc1);
                end else begin
                    e1 = q1.pop_front();
                    chk("ref1", ref1, e1.ref_l);
                    chk("pwr1", pwr1, e1.pwr);
                    chk("wc1", wc1, e1.wc);
`ifdef MAG_EST_DC_OFFSET_EN
                    chk("dc1", $signed(dc1), $signed(e1.dc[17:0]));
`endif
                end
            end
            if (v2) begin
                if (q2.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_valid_dut2: est_valid=1, expected 0 (wc=%0d)", wc2);
                end else begin
                    e2 = q2.pop_front();
                    chk("ref2", ref2, e2.ref_l);
                    chk("pwr2", pwr2, e2.pwr);
                    chk("wc2", wc2, e2.wc);
`ifdef MAG_EST_DC_OFFSET_EN
                    chk("dc2_i", $signed(dc2[17:0]), $signed(e2.dc[17:0]));
                    chk("dc2_q", $signed(dc2[35:18]), $signed(e2.dc[35:18]));
`endif
                end
            end
        end
    end

    initial begin
        reset   = 1'b1;
        restart = 1'b0;
        sym1    = 1'b0;
        sym2    = 1'b0;
        dv1     = '0;
        dv2     = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        chk("reset_ref1", ref1, 0);
        chk("reset_pwr1", pwr1, 0);
        chk("reset_valid1", v1, 0);
        chk("reset_wc1", wc1, 0);
        chk("reset_ref2", ref2, 0);

        // 1: four samples of 0.5
        win1(18'h10000);
        push1(18'sd65536, 40'sd21474836480, 8'd1, 36'h10000);
        chk("ref1_at_T", ref1, 65536);
        chk("valid1_at_T", v1, 0);
        idle(5);

        // 2: alternating signs with idle gaps
        send1(18'h08000, 1);
        send1(18'h38000, 3);
        send1(18'h08000, 2);
        send1(18'h38000, 0);
        push1(18'sd32768, 40'sd5368709120, 8'd2, 36'h0);
        idle(5);

        // 3: most negative input saturates
        win1(18'h20000);
        push1(18'sd131071, 40'sd85898035205, 8'd3, 36'h20000);
        idle(5);

        // 4: two channels, I=0.5, Q=-0.25
        for (int i = 0; i < 4; i++) send2({18'h38000, 18'h10000});
        push2(18'sd49152, 40'sd12079595520, 8'd1, {18'h38000, 18'h10000});
        idle(5);

        // 5a: restart after two samples
        send1(18'd100000, 0);
        send1(18'd100000, 0);
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
        idle(3);
        chk("ref1_held_after_restart", ref1, 131071);
        chk("wc1_held_after_restart", wc1, 3);
        win1(18'd16384);
        push1(18'sd16384, 40'sd1342177280, 8'd4, 36'd16384);
        idle(5);

        // 5b: restart coincident with the terminal sample
        send1(18'd8192, 0);
        send1(18'd8192, 0);
        send1(18'd8192, 0);
        sym1    = 1'b1;
        dv1     = 18'd8192;
        restart = 1'b1;
        @(posedge clk);
        #1;
        sym1    = 1'b0;
        restart = 1'b0;
        idle(5);
        chk("ref1_held_after_coincident_restart", ref1, 16384);
        chk("wc1_held_after_coincident_restart", wc1, 4);

        // 5c: restart at T+1 does not cancel the pending power update
        win1(18'd4096);
        push1(18'sd4096, 40'sd83886080, 8'd5, 36'd4096);
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
        idle(5);

        // 6a: reset mid-window
        send1(18'h10000, 0);
        send1(18'h10000, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("ref1_after_reset", ref1, 0);
        chk("pwr1_after_reset", pwr1, 0);
        chk("wc1_after_reset", wc1, 0);
        chk("valid1_after_reset", v1, 0);
        chk("wc2_after_reset", wc2, 0);
        chk("ref2_after_reset", ref2, 0);

        // 6b: reset one cycle after a terminal sample suppresses the pending update
        win1(18'h10000);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("ref1_after_reset_T1", ref1, 0);
        chk("pwr1_after_reset_T1", pwr1, 0);
        chk("wc1_after_reset_T1", wc1, 0);
        idle(3);

        // 6c: the following window reports normally
        win1(18'h08000);
        push1(18'sd32768, 40'sd5368709120, 8'd1, 36'h08000);
        idle(6);

        chk("sb1_drained", q1.size(), 0);
        chk("sb2_drained", q2.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
